// File: rtl/memory_pipelined.sv
// memory_pipelined: single-port RAM with valid/ready requests, byte-lane writes, an RD_LAT-stage
// read pipeline and a first-word-fall-through response FIFO. Define MEMORY_PIPELINED_OOR_CHECK_EN to enable range checks.
module memory_pipelined #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b1}}
) (
  input  logic                clk_i,
  input  logic                srst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  localparam int unsigned      NB       = DATA_W / 8;
  localparam int unsigned      IDX_W    = $clog2(DEPTH);
  localparam int unsigned      FIFO_D   = RD_LAT + 1;
  localparam int unsigned      PTR_W    = $clog2(FIFO_D);
  localparam int unsigned      CNT_W    = $clog2(FIFO_D + 1);
  localparam int unsigned      LAST     = RD_LAT - 1;
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(FIFO_D);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_D - 1);

  logic [IDX_W-1:0] word_idx;
  logic             oor;
  logic             req_fire, rd_fire, wr_fire;

  assign word_idx = req_addr_i[IDX_W-1:0];

`ifdef MEMORY_PIPELINED_OOR_CHECK_EN
  assign oor = (req_addr_i >> IDX_W) != '0;
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^(req_addr_i >> IDX_W);
`endif

  // Reset dominates: nothing presented on a reset edge is accepted, including writes.
  logic ready_q, ready_d;
  assign req_ready_o = ready_q;
  assign req_fire    = req_valid_i && ready_q && srst_ni;
  assign rd_fire     = req_fire && !req_we_i;
  assign wr_fire     = req_fire && req_we_i && !oor;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  // NOTE: storage arrays are deliberately left out of reset; contents must survive srst_ni and stay RAM-mappable.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int k = 0; k < NB; k++) begin
        if (req_be_i[k]) mem_q[word_idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
      end
    end
  end

  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_err_q, pipe_err_d;
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];
  logic [DATA_W-1:0] pipe_data_d [RD_LAT];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_err_d     = pipe_err_q;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = rd_fire;
    pipe_err_d[0]  = oor;
    pipe_data_d[0] = oor ? '0 : mem_q[word_idx];
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_err_d[s]  = pipe_err_q[s-1];
      pipe_data_d[s] = pipe_data_q[s-1];
    end
  end

  logic              last_vld, last_err;
  logic [DATA_W-1:0] last_data;
  assign last_vld  = pipe_vld_q[LAST];
  assign last_err  = pipe_err_q[LAST];
  assign last_data = pipe_data_q[LAST];

  logic [DATA_W-1:0] fifo_data_q [FIFO_D];
  logic [FIFO_D-1:0] fifo_err_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, outst_q, outst_d;
  logic              fifo_empty, push, fifo_pop, rsp_fire, rsp_valid, head_err;
  logic [DATA_W-1:0] head_data;

  // An empty FIFO is bypassed so the last stage can be consumed in the cycle it becomes valid.
  assign fifo_empty = (cnt_q == '0);
  assign rsp_valid  = !fifo_empty || last_vld;
  assign head_data  = fifo_empty ? last_data : fifo_data_q[rd_ptr_q];
  assign head_err   = fifo_empty ? last_err : fifo_err_q[rd_ptr_q];
  assign rsp_fire   = rsp_valid && rsp_ready_i;
  assign fifo_pop   = !fifo_empty && rsp_ready_i;
  assign push       = last_vld && !(fifo_empty && rsp_ready_i);

  assign rsp_valid_o = rsp_valid;
  assign rsp_rdata_o = rsp_valid ? head_data : '0;
  assign rsp_err_o   = rsp_valid && head_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !fifo_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && fifo_pop) cnt_d = cnt_q - CNT_W'(1);
    outst_d  = outst_q;
    if (rd_fire && !rsp_fire)      outst_d = outst_q + CNT_W'(1);
    else if (!rd_fire && rsp_fire) outst_d = outst_q - CNT_W'(1);
    ready_d  = (outst_d < MAX_OUT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      outst_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_data_q <= pipe_data_d;
    pipe_err_q  <= pipe_err_d;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= last_data;
      fifo_err_q[wr_ptr_q]  <= last_err;
    end
  end

endmodule

// File: doc/memory_pipelined.md
# memory_pipelined

Parametrised single-port synchronous memory with a valid/ready request channel, byte-lane write enables, configurable read latency and a backpressured read-response channel. It is the general-purpose storage block for testbench DUTs and datapath buffers, replacing fixed 1024x32 single-cycle memories wherever width, depth, latency or flow control must vary.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 16, request address width
- DEPTH, 1024, number of words; power of two, DEPTH <= 2**ADDR_W
- RD_LAT, 1, read latency in cycles, 1..4
- INIT_VAL, {DATA_W{1'b1}}, contents of every word at elaboration
- clk_i  input  1  clock; all logic on rising edge
- srst_ni  input  1  synchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when high with req_valid_i
- req_we_i  input  1  1 = write, 0 = read
- req_addr_i  input  ADDR_W  word address
- req_wdata_i  input  DATA_W  write data
- req_be_i  input  DATA_W/8  byte enables, writes only; bit k enables bits 8k+7:8k
- rsp_valid_o  output  1  read response valid
- rsp_ready_i  input  1  response consumer ready
- rsp_rdata_o  output  DATA_W  read data
- rsp_err_o  output  1  response error (out-of-range read)

## Operation
- Handshake: request transfers on a rising edge with req_valid_i && req_ready_o; response transfers with rsp_valid_o && rsp_ready_i. Request fields are sampled only at transfer.
- Write: at the transfer edge, each byte lane with req_be_i[k]=1 is updated; other lanes keep their value. be = 0 is a legal no-op. Writes produce no response.
- Read: enters an RD_LAT-stage pipeline (stage 1 is the RAM read register), then a first-word-fall-through response FIFO of depth RD_LAT+1. Responses are returned strictly in request order.
- Credit: counter `outstanding` = reads accepted and not yet popped, range 0..RD_LAT+1. It increments on read transfer, decrements on response transfer, and is unchanged when both occur in the same cycle. req_ready_o = (outstanding < RD_LAT+1), registered-path only, with no combinational path from rsp_ready_i or req_valid_i. req_ready_o gates writes as well as reads. The FIFO therefore never overflows.
- Ordering: one request per cycle. A read accepted the cycle after a write to the same address returns the new data.
- Address: word index = req_addr_i[$clog2(DEPTH)-1:0]; upper bits are handled according to Configuration.
- Reset (srst_ni=0 at an edge): the pipeline and FIFO are flushed and outstanding=0. Output values are req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Requests presented during reset are not accepted and memory contents are unchanged. req_ready_o=1 on the first cycle after reset is released. A reset mid-burst drops all in-flight reads with no late responses.
- Memory contents are never cleared by reset; they hold INIT_VAL only at elaboration.

## Timing
- Read accepted at edge T: with an empty FIFO and rsp_ready_i=1, rsp_valid_o is high during cycle T+RD_LAT and the response pops at edge T+RD_LAT.
- Throughput is one read per cycle sustained when rsp_ready_i is held high.
- Under backpressure, rsp_rdata_o and rsp_err_o are stable while rsp_valid_o=1 and rsp_ready_i=0.
- Writes are visible to reads accepted at edge T+1 or later.

## Configuration
- MEMORY_PIPELINED_OOR_CHECK_EN defined: an address with any nonzero bit at or above $clog2(DEPTH) is out of range.
  - Out-of-range writes are dropped with no state change.
  - Out-of-range reads still occupy a pipeline slot and return rsp_rdata_o=0 with rsp_err_o=1.
- Not defined: upper address bits are ignored, so addresses wrap modulo DEPTH, and rsp_err_o is tied to 0.

## Test plan
- Reset then read addresses 0 and DEPTH-1 with RD_LAT=1: each read returns 32'hFFFFFFFF with err=0, rsp_valid_o one cycle after its accept, and req_ready_o=0 during reset.
- Write 0xDEADBEEF to address 5 with be=4'b0101, then read address 5 the next cycle: returns 0xFFADFFEF.
- RD_LAT=3, 8 back-to-back reads with rsp_ready_i=1: 8 responses arrive on consecutive cycles starting at accept+3, in order, with req_ready_o never low.
- RD_LAT=2, rsp_ready_i=0, continuous read requests: exactly 3 reads are accepted and req_ready_o drops. After rsp_ready_i=1 the 3 responses pop in order, req_ready_o rises again, and data is held stable while stalled.
- Address 1024 with DEPTH=1024: with the macro, a write is dropped and a read returns 0 with err=1. Without the macro, the write aliases address 0 and a read of address 0 returns the written data.
- Assert srst_ni=0 with 2 reads in flight: no rsp_valid_o ever appears for those reads, and post-reset reads show memory contents unchanged.
